carfield_l2_port_splitter: RTL and testbench
============================================

CARFIELD_L2_PORT_SPLITTER -- requirements
Module: carfield_l2_port_splitter

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, meaning request address width.
REQ-002 SHALL have parameter DataWidth, default 64, meaning data width; byte-enable width is DataWidth/8.
REQ-003 SHALL have parameter L2Port0Base, default 'h78000000, meaning port 0 window base (64-bit).
REQ-004 SHALL have parameter L2Port0Size, default 'h00200000, meaning port 0 window size.
REQ-005 SHALL have parameter L2Port1Base, default 'h78200000, meaning port 1 window base.
REQ-006 SHALL have parameter L2Port1Size, default 'h00200000, meaning port 1 window size.
REQ-007 SHALL have parameter MaxOutstanding, default 4, meaning maximum accepted-but-unanswered requests (1..15).
REQ-008 SHALL have ports: clk_i in 1, the single clock; rst_ni in 1, asynchronous active-low reset.
REQ-009 SHALL have upstream ports: req_i in 1; gnt_o out 1; addr_i in AddrWidth; we_i in 1; wdata_i in DataWidth; be_i in DataWidth/8; rvalid_o out 1; rdata_o out DataWidth; err_o out 1.
REQ-010 SHALL have, for each port k in {0,1}: mk_req_o out 1; mk_gnt_i in 1; mk_addr_o out AddrWidth; mk_we_o out 1; mk_wdata_o out DataWidth; mk_be_o out DataWidth/8; mk_rvalid_i in 1; mk_rdata_i in DataWidth.
REQ-011 SHALL have status output spurious_o out 1, sticky flag for unexpected port responses.

Function
REQ-012 SHALL decode target combinationally: P0 if Base0 <= addr_i < Base0+Size0; else P1 if Base1 <= addr_i < Base1+Size1; else ERR; comparisons in 64-bit unsigned, addr_i zero-extended.
REQ-013 SHALL track state IDLE, BUSY_P0, BUSY_P1, BUSY_ERR plus outstanding counter cnt (0..MaxOutstanding).
REQ-014 SHALL be issue-eligible when cnt < MaxOutstanding and (state IDLE or decoded target equals the busy target); otherwise stall: no mk_req_o, gnt_o=0.
REQ-015 SHALL, when eligible and target Pk, drive mk_req_o=req_i with addr/we/wdata/be passed through unchanged (full address) and gnt_o=mk_gnt_i; the other port's req SHALL be 0.
REQ-016 SHALL, when eligible and target ERR, assert gnt_o=req_i without driving any port.
REQ-017 SHALL count a handshake (req_i & gnt_o) as acceptance: cnt+1, state -> BUSY_<target>.
REQ-018 SHALL in BUSY_Pk forward mk_rvalid_i to rvalid_o, mk_rdata_i to rdata_o, err_o=0, same cycle (zero added response latency); each is a completion: cnt-1.
REQ-019 SHALL in BUSY_ERR emit one response per cycle per outstanding ERR request starting the cycle after acceptance: rvalid_o=1, rdata_o=0, err_o=1, cnt-1.
REQ-020 SHALL on simultaneous acceptance and completion leave cnt unchanged and state unchanged.
REQ-021 SHALL return to IDLE when cnt reaches 0 with no same-cycle acceptance.
REQ-022 SHALL ignore mk_rvalid_i from a port not matching the busy state (including in IDLE), not forward it, and set spurious_o=1 until reset.
REQ-023 SHALL keep request-side outputs purely combinational from inputs and state; gnt_o SHALL NOT depend on rvalid inputs.
REQ-024 SHALL hold rvalid_o=0, err_o=0, rdata_o=0 when no response is forwarded.
REQ-025 SHALL not drop a held upstream request: req_i/addr_i stable until gnt_o is the upstream contract; no internal buffering of requests.

Reset
REQ-026 SHALL on rst_ni=0 asynchronously force state IDLE, cnt=0, spurious_o=0; gnt_o, rvalid_o, err_o, mk_req_o 0 while req_i=0.
REQ-027 SHALL discard outstanding bookkeeping on reset mid-operation; responses arriving after reset release in IDLE are treated per REQ-022.

Verification
REQ-028 Read addr 'h78000010, m0_gnt_i=1, m0_rvalid_i next cycle with 'hDEAD -> m0_req_o=1, gnt_o=1, then rvalid_o=1, rdata_o='hDEAD, err_o=0; m1_req_o never 1.
REQ-029 Four back-to-back reads to 'h78200000.. with m1_rvalid_i withheld -> 4 grants, 5th gnt_o=0 until one m1_rvalid_i, then granted.
REQ-030 Outstanding read to P0, next req to 'h78200000 -> gnt_o=0, m1_req_o=0 until P0 response returns and state IDLE, then m1_req_o=1.
REQ-031 Write to 'h10000000 -> gnt_o=1 same cycle, next cycle rvalid_o=1, err_o=1, rdata_o=0; no port request.
REQ-032 Boundary: 'h783FFFF8 -> P1; 'h78400000 -> ERR; 'h77FFFFFF -> ERR.
REQ-033 m0_rvalid_i pulse in IDLE -> rvalid_o=0, spurious_o=1 held; rst_ni low mid-burst -> cnt=0, IDLE, spurious_o=0.

Source files
------------

// File: rtl/carfield_l2_port_splitter.sv
// Carfield L2 port splitter: routes one upstream request stream to one of two
// L2 ports (or an internal error responder) based on the address window, while
// keeping all outstanding requests on a single target so responses stay ordered.
module carfield_l2_port_splitter #(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter logic [63:0] L2Port0Base    = 64'h0000_0000_7800_0000,
    parameter logic [63:0] L2Port0Size    = 64'h0000_0000_0020_0000,
    parameter logic [63:0] L2Port1Base    = 64'h0000_0000_7820_0000,
    parameter logic [63:0] L2Port1Size    = 64'h0000_0000_0020_0000,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // upstream
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    // port 0
    output logic                   m0_req_o,
    input  logic                   m0_gnt_i,
    output logic [AddrWidth-1:0]   m0_addr_o,
    output logic                   m0_we_o,
    output logic [DataWidth-1:0]   m0_wdata_o,
    output logic [DataWidth/8-1:0] m0_be_o,
    input  logic                   m0_rvalid_i,
    input  logic [DataWidth-1:0]   m0_rdata_i,
    // port 1
    output logic                   m1_req_o,
    input  logic                   m1_gnt_i,
    output logic [AddrWidth-1:0]   m1_addr_o,
    output logic                   m1_we_o,
    output logic [DataWidth-1:0]   m1_wdata_o,
    output logic [DataWidth/8-1:0] m1_be_o,
    input  logic                   m1_rvalid_i,
    input  logic [DataWidth-1:0]   m1_rdata_i,
    // status
    output logic                   spurious_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
    localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [63:0] L2Port0End = L2Port0Base + L2Port0Size;
    localparam logic [63:0] L2Port1End = L2Port1Base + L2Port1Size;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_P0  = 2'd1,
        ST_BUSY_P1  = 2'd2,
        ST_BUSY_ERR = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TGT_P0  = 2'd0,
        TGT_P1  = 2'd1,
        TGT_ERR = 2'd2
    } tgt_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            spurious_q, spurious_d;

    logic [63:0] addr_ext;
    tgt_e        tgt;
    logic        eligible;
    logic        accept;
    logic        complete;

    // Address passthrough: the selected port's req is the only qualifier.
    assign m0_addr_o  = addr_i;
    assign m0_we_o    = we_i;
    assign m0_wdata_o = wdata_i;
    assign m0_be_o    = be_i;
    assign m1_addr_o  = addr_i;
    assign m1_we_o    = we_i;
    assign m1_wdata_o = wdata_i;
    assign m1_be_o    = be_i;
    assign spurious_o = spurious_q;

    // Decode the target window from the zero-extended address.
    always_comb begin
        addr_ext = 64'(addr_i);
        if ((addr_ext >= L2Port0Base) && (addr_ext < L2Port0End)) begin
            tgt = TGT_P0;
        end else if ((addr_ext >= L2Port1Base) && (addr_ext < L2Port1End)) begin
            tgt = TGT_P1;
        end else begin
            tgt = TGT_ERR;
        end
    end

    // Request side: issue only when capacity remains and the target matches the busy one.
    always_comb begin
        eligible = 1'b0;
        m0_req_o = 1'b0;
        m1_req_o = 1'b0;
        gnt_o    = 1'b0;
        if (cnt_q < MaxCnt) begin
            case (state_q)
                ST_IDLE:     eligible = 1'b1;
                ST_BUSY_P0:  eligible = (tgt == TGT_P0);
                ST_BUSY_P1:  eligible = (tgt == TGT_P1);
                ST_BUSY_ERR: eligible = (tgt == TGT_ERR);
                default:     eligible = 1'b0;
            endcase
        end else begin
            eligible = 1'b0;
        end
        if (eligible) begin
            case (tgt)
                TGT_P0: begin
                    m0_req_o = req_i;
                    gnt_o    = req_i & m0_gnt_i;
                end
                TGT_P1: begin
                    m1_req_o = req_i;
                    gnt_o    = req_i & m1_gnt_i;
                end
                TGT_ERR: gnt_o = req_i;
                default: gnt_o = 1'b0;
            endcase
        end else begin
            gnt_o = 1'b0;
        end
    end

    assign accept = req_i & gnt_o;

    // Response side: forward the busy port's response or generate error responses.
    always_comb begin
        rvalid_o   = 1'b0;
        rdata_o    = {DataWidth{1'b0}};
        err_o      = 1'b0;
        complete   = 1'b0;
        spurious_d = spurious_q;
        case (state_q)
            ST_BUSY_P0: begin
                if (m0_rvalid_i && (cnt_q != CntZero)) begin
                    rvalid_o = 1'b1;
                    rdata_o  = m0_rdata_i;
                    complete = 1'b1;
                end else begin
                    complete = 1'b0;
                end
            end
            ST_BUSY_P1: begin
                if (m1_rvalid_i && (cnt_q != CntZero)) begin
                    rvalid_o = 1'b1;
                    rdata_o  = m1_rdata_i;
                    complete = 1'b1;
                end else begin
                    complete = 1'b0;
                end
            end
            ST_BUSY_ERR: begin
                if (cnt_q != CntZero) begin
                    rvalid_o = 1'b1;
                    err_o    = 1'b1;
                    complete = 1'b1;
                end else begin
                    complete = 1'b0;
                end
            end
            default: complete = 1'b0;
        endcase
        // Any response from a port that is not the one we are waiting on is dropped and flagged.
        if ((m0_rvalid_i && !((state_q == ST_BUSY_P0) && (cnt_q != CntZero))) ||
            (m1_rvalid_i && !((state_q == ST_BUSY_P1) && (cnt_q != CntZero)))) begin
            spurious_d = 1'b1;
        end else begin
            spurious_d = spurious_q;
        end
    end

    // Next-state and outstanding-count update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case ({accept, complete})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
        if (accept) begin
            case (tgt)
                TGT_P0:  state_d = ST_BUSY_P0;
                TGT_P1:  state_d = ST_BUSY_P1;
                TGT_ERR: state_d = ST_BUSY_ERR;
                default: state_d = ST_IDLE;
            endcase
        end else if (cnt_d == CntZero) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State, counter and sticky spurious flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CntZero;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
        end
    end

endmodule

// File: tb/tb_carfield_l2_port_splitter.sv
// Directed testbench for carfield_l2_port_splitter with default parameters.
module tb_carfield_l2_port_splitter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [47:0] addr_i = 48'h0;
    logic        we_i = 1'b0;
    logic [63:0] wdata_i = 64'h0;
    logic [7:0]  be_i = 8'h0;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        err_o;
    logic        m0_req_o, m0_we_o, m1_req_o, m1_we_o;
    logic        m0_gnt_i = 1'b0, m1_gnt_i = 1'b0;
    logic [47:0] m0_addr_o, m1_addr_o;
    logic [63:0] m0_wdata_o, m1_wdata_o;
    logic [7:0]  m0_be_o, m1_be_o;
    logic        m0_rvalid_i = 1'b0, m1_rvalid_i = 1'b0;
    logic [63:0] m0_rdata_i = 64'h0, m1_rdata_i = 64'h0;
    logic        spurious_o;

    int n_assert = 0;
    int n_fail   = 0;

    carfield_l2_port_splitter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .be_i(be_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .m0_req_o(m0_req_o), .m0_gnt_i(m0_gnt_i), .m0_addr_o(m0_addr_o),
        .m0_we_o(m0_we_o), .m0_wdata_o(m0_wdata_o), .m0_be_o(m0_be_o),
        .m0_rvalid_i(m0_rvalid_i), .m0_rdata_i(m0_rdata_i),
        .m1_req_o(m1_req_o), .m1_gnt_i(m1_gnt_i), .m1_addr_o(m1_addr_o),
        .m1_we_o(m1_we_o), .m1_wdata_o(m1_wdata_o), .m1_be_o(m1_be_o),
        .m1_rvalid_i(m1_rvalid_i), .m1_rdata_i(m1_rdata_i),
        .spurious_o(spurious_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        chk("rst_gnt", gnt_o, 64'd0);
        chk("rst_rvalid", rvalid_o, 64'd0);
        chk("rst_err", err_o, 64'd0);
        chk("rst_m0_req", m0_req_o, 64'd0);
        chk("rst_m1_req", m1_req_o, 64'd0);
        chk("rst_spurious", spurious_o, 64'd0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();

        // ---------------- single read to P0 ----------------
        req_i = 1'b1; addr_i = 48'h7800_0010; we_i = 1'b0; m0_gnt_i = 1'b1;
        be_i = 8'hFF; wdata_i = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("p0rd_m0_req", m0_req_o, 64'd1);
        chk("p0rd_m1_req", m1_req_o, 64'd0);
        chk("p0rd_gnt", gnt_o, 64'd1);
        chk("p0rd_addr", m0_addr_o, 64'h7800_0010);
        chk("p0rd_wdata", m0_wdata_o, 64'h0123_4567_89AB_CDEF);
        chk("p0rd_rvalid_early", rvalid_o, 64'd0);
        cyc();
        req_i = 1'b0; m0_rvalid_i = 1'b1; m0_rdata_i = 64'hDEAD;
        #1;
        chk("p0rd_rvalid", rvalid_o, 64'd1);
        chk("p0rd_rdata", rdata_o, 64'hDEAD);
        chk("p0rd_err", err_o, 64'd0);
        chk("p0rd_m1_req_resp", m1_req_o, 64'd0);
        cyc();
        m0_rvalid_i = 1'b0; m0_gnt_i = 1'b0;
        #1;
        chk("p0rd_rvalid_after", rvalid_o, 64'd0);
        chk("p0rd_rdata_after", rdata_o, 64'd0);

        // ---------------- outstanding limit on P1 ----------------
        req_i = 1'b1; m1_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_i = 48'h7820_0000 + 48'(i * 8);
            #1;
            chk("lim_gnt", gnt_o, 64'd1);
            chk("lim_m1_req", m1_req_o, 64'd1);
            cyc();
        end
        addr_i = 48'h7820_0020;
        #1;
        chk("lim_5th_gnt", gnt_o, 64'd0);
        chk("lim_5th_m1_req", m1_req_o, 64'd0);
        cyc();
        chk("lim_5th_gnt_hold", gnt_o, 64'd0);
        m1_rvalid_i = 1'b1; m1_rdata_i = 64'h1111;
        #1;
        chk("lim_gnt_indep_rvalid", gnt_o, 64'd0);
        chk("lim_rvalid", rvalid_o, 64'd1);
        chk("lim_rdata", rdata_o, 64'h1111);
        cyc();
        m1_rvalid_i = 1'b0;
        #1;
        chk("lim_5th_granted", gnt_o, 64'd1);
        chk("lim_5th_m1_req_now", m1_req_o, 64'd1);
        cyc();
        req_i = 1'b0; m1_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m1_rdata_i = 64'h2000 + 64'(i);
            #1;
            chk("lim_drain_rdata", rdata_o, 64'h2000 + 64'(i));
            cyc();
        end
        m1_rvalid_i = 1'b0; m1_gnt_i = 1'b0;
        #1;
        chk("lim_no_spurious", spurious_o, 64'd0);

        // ---------------- target switch stall ----------------
        req_i = 1'b1; addr_i = 48'h7800_0000; m0_gnt_i = 1'b1;
        #1;
        chk("sw_p0_gnt", gnt_o, 64'd1);
        cyc();
        addr_i = 48'h7820_0000; m1_gnt_i = 1'b1;
        #1;
        chk("sw_stall_gnt", gnt_o, 64'd0);
        chk("sw_stall_m1_req", m1_req_o, 64'd0);
        chk("sw_stall_m0_req", m0_req_o, 64'd0);
        cyc();
        m0_rvalid_i = 1'b1; m0_rdata_i = 64'h1234;
        #1;
        chk("sw_resp_gnt", gnt_o, 64'd0);
        chk("sw_resp_rvalid", rvalid_o, 64'd1);
        chk("sw_resp_rdata", rdata_o, 64'h1234);
        cyc();
        m0_rvalid_i = 1'b0;
        #1;
        chk("sw_m1_req", m1_req_o, 64'd1);
        chk("sw_m1_gnt", gnt_o, 64'd1);
        cyc();
        req_i = 1'b0; m1_rvalid_i = 1'b1; m1_rdata_i = 64'h5678;
        #1;
        chk("sw_p1_rdata", rdata_o, 64'h5678);
        cyc();
        m1_rvalid_i = 1'b0; m0_gnt_i = 1'b0; m1_gnt_i = 1'b0;

        // ---------------- error response ----------------
        req_i = 1'b1; we_i = 1'b1; addr_i = 48'h1000_0000;
        #1;
        chk("err_gnt", gnt_o, 64'd1);
        chk("err_m0_req", m0_req_o, 64'd0);
        chk("err_m1_req", m1_req_o, 64'd0);
        chk("err_rvalid_same", rvalid_o, 64'd0);
        cyc();
        req_i = 1'b0; we_i = 1'b0;
        #1;
        chk("err_rvalid", rvalid_o, 64'd1);
        chk("err_err", err_o, 64'd1);
        chk("err_rdata", rdata_o, 64'd0);
        cyc();
        chk("err_rvalid_done", rvalid_o, 64'd0);
        chk("err_err_done", err_o, 64'd0);

        // ---------------- boundaries (no port grants, so nothing is accepted on ports) ----------------
        req_i = 1'b1; addr_i = 48'h783F_FFF8;
        #1;
        chk("bnd_p1_top_m1", m1_req_o, 64'd1);
        chk("bnd_p1_top_m0", m0_req_o, 64'd0);
        chk("bnd_p1_top_gnt", gnt_o, 64'd0);
        addr_i = 48'h781F_FFF8;
        #1;
        chk("bnd_p0_top_m0", m0_req_o, 64'd1);
        addr_i = 48'h7840_0000;
        #1;
        chk("bnd_p1_end_gnt", gnt_o, 64'd1);
        chk("bnd_p1_end_m1", m1_req_o, 64'd0);
        addr_i = 48'h77FF_FFFF;
        #1;
        chk("bnd_below_gnt", gnt_o, 64'd1);
        chk("bnd_below_m0", m0_req_o, 64'd0);
        req_i = 1'b0;
        cyc();

        // ---------------- spurious response in IDLE ----------------
        m0_rvalid_i = 1'b1; m0_rdata_i = 64'hBEEF;
        #1;
        chk("spu_rvalid", rvalid_o, 64'd0);
        chk("spu_rdata", rdata_o, 64'd0);
        cyc();
        m0_rvalid_i = 1'b0;
        chk("spu_flag", spurious_o, 64'd1);
        cyc();
        chk("spu_flag_held", spurious_o, 64'd1);

        // ---------------- reset mid-burst ----------------
        req_i = 1'b1; addr_i = 48'h7820_0100; m1_gnt_i = 1'b1;
        cyc();
        cyc();
        req_i = 1'b0; m1_gnt_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mrst_spurious", spurious_o, 64'd0);
        chk("mrst_rvalid", rvalid_o, 64'd0);
        cyc();
        rst_ni = 1'b1;
        m1_rvalid_i = 1'b1; m1_rdata_i = 64'hCAFE;
        #1;
        chk("mrst_late_rvalid", rvalid_o, 64'd0);
        cyc();
        m1_rvalid_i = 1'b0;
        chk("mrst_late_spurious", spurious_o, 64'd1);
        // Idle with zero count: a P0 request is eligible straight away.
        req_i = 1'b1; addr_i = 48'h7800_0040; m0_gnt_i = 1'b1;
        #1;
        chk("mrst_idle_p0_gnt", gnt_o, 64'd1);
        req_i = 1'b0; m0_gnt_i = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
